// File: rtl/sseg_scan_driver.sv
// Time-multiplexed N-digit seven-segment scanner with shadowed inputs,
// leading-zero blanking, per-digit enables, decimal points and frame strobe.
module sseg_scan_driver #(
   parameter int unsigned NUM_DIGITS     = 4,
   parameter int unsigned REFRESH_DIV    = 100000,
   parameter logic        SEG_ACTIVE_LOW = 1'b1,
   parameter logic        AN_ACTIVE_LOW  = 1'b1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic [NUM_DIGITS-1:0]   digit_en,
   input  logic                    lz_blank,
   input  logic                    load,
   output logic [6:0]              seg,
   output logic                    dp,
   output logic [NUM_DIGITS-1:0]   an,
   output logic                    frame_done
);

   localparam int unsigned CW = $clog2(REFRESH_DIV);
   localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
   localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);
   localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
   localparam logic [NUM_DIGITS-1:0] AN_OFF = AN_ACTIVE_LOW ? '1 : '0;

   logic [CW-1:0]           cnt_q, cnt_d;
   logic [IW-1:0]           idx_q, idx_d;
   logic                    fd_q, fd_d;
   logic [4*NUM_DIGITS-1:0] val_q, val_d;
   logic [NUM_DIGITS-1:0]   dp_sh_q, dp_sh_d;
   logic [NUM_DIGITS-1:0]   en_sh_q, en_sh_d;
   logic                    lz_sh_q, lz_sh_d;
   logic [6:0]              seg_q, seg_d;
   logic                    dp_q, dp_d;
   logic [NUM_DIGITS-1:0]   an_q, an_d;

   logic [NUM_DIGITS-1:0]   lz_mask;
   logic                    all_zero;
   logic [3:0]              nib;
   logic [6:0]              seg_on;
   logic                    dp_on;
   logic [NUM_DIGITS-1:0]   an_on;

   // Active-high gfedcba patterns
   function automatic logic [6:0] decode(input logic [3:0] n);
      case (n)
         4'h0:    decode = 7'b0111111;
         4'h1:    decode = 7'b0000110;
         4'h2:    decode = 7'b1011011;
         4'h3:    decode = 7'b1001111;
         4'h4:    decode = 7'b1100110;
         4'h5:    decode = 7'b1101101;
         4'h6:    decode = 7'b1111101;
         4'h7:    decode = 7'b0000111;
         4'h8:    decode = 7'b1111111;
         4'h9:    decode = 7'b1101111;
         4'hA:    decode = 7'b1110111;
         4'hB:    decode = 7'b1111100;
         4'hC:    decode = 7'b0111001;
         4'hD:    decode = 7'b1011110;
         4'hE:    decode = 7'b1111001;
         default: decode = 7'b1110001;
      endcase
   endfunction

   always_comb begin
      cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
      idx_d = idx_q;
      fd_d  = 1'b0;
      if (cnt_q == CNT_MAX) begin
         if (idx_q == IDX_MAX) begin
            idx_d = '0;
            fd_d  = 1'b1;
         end else begin
            idx_d = idx_q + 1'b1;
         end
      end
      val_d   = load ? value    : val_q;
      dp_sh_d = load ? dp_in    : dp_sh_q;
      en_sh_d = load ? digit_en : en_sh_q;
      lz_sh_d = load ? lz_blank : lz_sh_q;
   end

   // Scan from the top digit down; a digit is a leading zero while every
   // nibble above and including it is zero. Digit 0 is exempt.
   always_comb begin
      all_zero = 1'b1;
      lz_mask  = '0;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
         all_zero = all_zero & (val_q[4*(NUM_DIGITS-1-i) +: 4] == 4'h0);
         if (i != NUM_DIGITS - 1)
            lz_mask[NUM_DIGITS-1-i] = all_zero;
      end
   end

   always_comb begin
      nib    = val_q[4*idx_q +: 4];
      seg_on = decode(nib);
      dp_on  = dp_sh_q[idx_q];
      an_on  = '0;
      an_on[idx_q] = 1'b1;
      if (!en_sh_q[idx_q]) begin
         seg_on = '0;
         dp_on  = 1'b0;
         an_on  = '0;
      end else if (lz_sh_q && lz_mask[idx_q]) begin
         seg_on = '0;
         dp_on  = 1'b0;
      end
      seg_d = seg_on ^ {7{SEG_ACTIVE_LOW}};
      dp_d  = dp_on ^ SEG_ACTIVE_LOW;
      an_d  = an_on ^ {NUM_DIGITS{AN_ACTIVE_LOW}};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         idx_q   <= '0;
         fd_q    <= 1'b0;
         val_q   <= '0;
         dp_sh_q <= '0;
         en_sh_q <= '0;
         lz_sh_q <= 1'b0;
         seg_q   <= SEG_OFF;
         dp_q    <= SEG_ACTIVE_LOW;
         an_q    <= AN_OFF;
      end else begin
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         fd_q    <= fd_d;
         val_q   <= val_d;
         dp_sh_q <= dp_sh_d;
         en_sh_q <= en_sh_d;
         lz_sh_q <= lz_sh_d;
         seg_q   <= seg_d;
         dp_q    <= dp_d;
         an_q    <= an_d;
      end
   end

   assign seg        = seg_q;
   assign dp         = dp_q;
   assign an         = an_q;
   assign frame_done = fd_q;

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Bench for sseg_scan_driver: low-true and high-true instances driven in
// parallel, expectations queued per output cycle and checked on negedge.
module tb_sseg_scan_driver;

   localparam int unsigned ND    = 4;
   localparam int unsigned DIV   = 4;
   localparam int unsigned FRAME = ND * DIV;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] value = '0;
   logic [3:0]  dp_in = '0;
   logic [3:0]  digit_en = '0;
   logic        lz_blank = 1'b0;
   logic        load = 1'b0;

   logic [6:0] seg_lo, seg_hi;
   logic       dp_lo, dp_hi, fd_lo, fd_hi;
   logic [3:0] an_lo, an_hi;

   always #5 clk = ~clk;

   sseg_scan_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(DIV),
                      .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) u_lo (
      .clk(clk), .rst_n(rst_n), .value(value), .dp_in(dp_in),
      .digit_en(digit_en), .lz_blank(lz_blank), .load(load),
      .seg(seg_lo), .dp(dp_lo), .an(an_lo), .frame_done(fd_lo));

   sseg_scan_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(DIV),
                      .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0)) u_hi (
      .clk(clk), .rst_n(rst_n), .value(value), .dp_in(dp_in),
      .digit_en(digit_en), .lz_blank(lz_blank), .load(load),
      .seg(seg_hi), .dp(dp_hi), .an(an_hi), .frame_done(fd_hi));

   // Edges since reset release: output after edge n shows slot ((n-1)/DIV)%ND
   int unsigned n;
   always @(posedge clk or negedge rst_n)
      if (!rst_n) n <= 0;
      else        n <= n + 1;

   int total = 0;
   int bad   = 0;

   typedef struct {
      int unsigned cyc;
      string       name;
      logic [6:0]  seg;   // low-true expectations; high-true instance gets the inverse
      logic        dp;
      logic [3:0]  an;
      logic        fd;
   } sb_t;
   sb_t sb_q[$];

   typedef struct {
      string       name;
      logic [15:0] val;
      logic [3:0]  dpi;
      logic [3:0]  en;
      logic        lz;
      int unsigned d;
      logic [6:0]  seg;
      logic        dpo;
      logic [3:0]  an;
   } vec_t;
   vec_t vecs[$];

   logic [6:0] dec_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
   logic [6:0] seg_12af [4] = '{7'h0E, 7'h08, 7'h24, 7'h79};
   logic [3:0] an_sel   [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

   task automatic compare(input sb_t e);
      logic [12:0] exp_lo, exp_hi, act_lo, act_hi;
      exp_lo = {e.seg, e.dp, e.an, e.fd};
      exp_hi = {~e.seg, ~e.dp, ~e.an, e.fd};
      act_lo = {seg_lo, dp_lo, an_lo, fd_lo};
      act_hi = {seg_hi, dp_hi, an_hi, fd_hi};
      total++;
      if (act_lo !== exp_lo) begin
         bad++;
         $display("FAIL %s lo cyc=%0d {seg,dp,an,fd} got=%b want=%b", e.name, n, act_lo, exp_lo);
      end
      total++;
      if (act_hi !== exp_hi) begin
         bad++;
         $display("FAIL %s hi cyc=%0d {seg,dp,an,fd} got=%b want=%b", e.name, n, act_hi, exp_hi);
      end
   endtask

   function automatic void push(input string name, input int unsigned t,
                                input logic [6:0] s, input logic d, input logic [3:0] a);
      sb_t e;
      e.cyc  = t;
      e.name = name;
      e.seg  = s;
      e.dp   = d;
      e.an   = a;
      e.fd   = (t % FRAME) == 0;
      sb_q.push_back(e);
   endfunction

   function automatic int unsigned slot_after(input int unsigned base, input int unsigned d);
      int unsigned t = base + 1;
      while ((((t - 1) / DIV) % ND) != d) t++;
      return t;
   endfunction

   function automatic vec_t mk(input string nm, input logic [15:0] v, input logic [3:0] dpi,
                               input logic [3:0] en, input logic lz, input int unsigned d,
                               input logic [6:0] s, input logic dpo, input logic [3:0] a);
      vec_t r;
      r.name = nm; r.val = v; r.dpi = dpi; r.en = en; r.lz = lz;
      r.d = d; r.seg = s; r.dpo = dpo; r.an = a;
      return r;
   endfunction

   always @(negedge clk) begin
      if (rst_n && sb_q.size() > 0) begin
         if (sb_q[0].cyc == n) begin
            compare(sb_q[0]);
            void'(sb_q.pop_front());
         end else if (sb_q[0].cyc < n) begin
            total++;
            bad++;
            $display("FAIL %s missed: cyc=%0d now=%0d", sb_q[0].name, sb_q[0].cyc, n);
            void'(sb_q.pop_front());
         end
      end
   end

   task automatic wait_until(input int unsigned t);
      while (n < t) @(negedge clk);
   endtask

   task automatic load_inputs(input logic [15:0] v, input logic [3:0] d,
                              input logic [3:0] e, input logic l);
      value = v; dp_in = d; digit_en = e; lz_blank = l; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
   endtask

   // Release reset with a load pending: first output cycle still shows the
   // cleared shadow, then digit 0 fills the remainder of its first slot.
   task automatic release_seq();
      value = 16'h12AF; dp_in = 4'h0; digit_en = 4'hF; lz_blank = 1'b0; load = 1'b1;
      rst_n = 1'b1;
      push("rel_blank", 1, 7'h7F, 1'b1, 4'hF);
      for (int unsigned t = 2; t <= 20; t++)
         push("rel_scan", t, seg_12af[((t - 1) / DIV) % ND], 1'b1, an_sel[((t - 1) / DIV) % ND]);
      @(negedge clk);
      load = 1'b0;
      wait_until(20);
   endtask

   initial begin
      int unsigned t, t2;
      sb_t e;

      vecs.push_back(mk("f_d0",   16'h12AF, 4'h0, 4'hF, 1'b0, 0, 7'h0E, 1'b1, 4'hE));
      vecs.push_back(mk("a_d1",   16'h12AF, 4'h0, 4'hF, 1'b0, 1, 7'h08, 1'b1, 4'hD));
      vecs.push_back(mk("two_d2", 16'h12AF, 4'h0, 4'hF, 1'b0, 2, 7'h24, 1'b1, 4'hB));
      vecs.push_back(mk("one_d3", 16'h12AF, 4'h0, 4'hF, 1'b0, 3, 7'h79, 1'b1, 4'h7));
      vecs.push_back(mk("lz5_d3", 16'h0005, 4'h0, 4'hF, 1'b1, 3, 7'h7F, 1'b1, 4'h7));
      vecs.push_back(mk("lz5_d2", 16'h0005, 4'h0, 4'hF, 1'b1, 2, 7'h7F, 1'b1, 4'hB));
      vecs.push_back(mk("lz5_d1", 16'h0005, 4'h0, 4'hF, 1'b1, 1, 7'h7F, 1'b1, 4'hD));
      vecs.push_back(mk("lz5_d0", 16'h0005, 4'h0, 4'hF, 1'b1, 0, 7'h12, 1'b1, 4'hE));
      vecs.push_back(mk("lz0_d0", 16'h0000, 4'h0, 4'hF, 1'b1, 0, 7'h40, 1'b1, 4'hE));
      vecs.push_back(mk("lz0_d1", 16'h0000, 4'h0, 4'hF, 1'b1, 1, 7'h7F, 1'b1, 4'hD));
      vecs.push_back(mk("lz50_d1",16'h0050, 4'h0, 4'hF, 1'b1, 1, 7'h12, 1'b1, 4'hD));
      vecs.push_back(mk("lz50_d0",16'h0050, 4'h0, 4'hF, 1'b1, 0, 7'h40, 1'b1, 4'hE));
      vecs.push_back(mk("nolz_d2",16'h1000, 4'h0, 4'hF, 1'b0, 2, 7'h40, 1'b1, 4'hB));
      vecs.push_back(mk("en_d0",  16'h8888, 4'h2, 4'hA, 1'b0, 0, 7'h7F, 1'b1, 4'hF));
      vecs.push_back(mk("en_d1",  16'h8888, 4'h2, 4'hA, 1'b0, 1, 7'h00, 1'b0, 4'hD));
      vecs.push_back(mk("en_d2",  16'h8888, 4'h2, 4'hA, 1'b0, 2, 7'h7F, 1'b1, 4'hF));
      vecs.push_back(mk("en_d3",  16'h8888, 4'h2, 4'hA, 1'b0, 3, 7'h00, 1'b1, 4'h7));

      // Power-on reset values
      repeat (3) @(negedge clk);
      e = '{cyc: 0, name: "por", seg: 7'h7F, dp: 1'b1, an: 4'hF, fd: 1'b0};
      compare(e);
      release_seq();

      foreach (vecs[i]) begin
         load_inputs(vecs[i].val, vecs[i].dpi, vecs[i].en, vecs[i].lz);
         t = slot_after(n, vecs[i].d);
         push(vecs[i].name, t, vecs[i].seg, vecs[i].dpo, vecs[i].an);
         wait_until(t);
      end

      // Unloaded input changes must not reach the display
      load_inputs(16'h12AF, 4'h0, 4'hF, 1'b0);
      value = 16'hFFFF; dp_in = 4'hF; digit_en = 4'h0; lz_blank = 1'b1;
      t  = slot_after(n, 1);
      t2 = slot_after(t, 3);
      push("hold_d1", t, 7'h08, 1'b1, 4'hD);
      push("hold_d3", t2, 7'h79, 1'b1, 4'h7);
      wait_until(t2);

      // Load on the same edge as the digit 0 -> 1 advance
      while (((n + 1) % FRAME) != 4) @(negedge clk);
      t = n + 1;
      push("adv_old", t, 7'h0E, 1'b1, 4'hE);
      push("adv_new", t + 1, 7'h30, 1'b1, 4'hD);
      value = 16'h0030; dp_in = 4'h0; digit_en = 4'hF; lz_blank = 1'b0; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      wait_until(t + 1);

      // Full nibble sweep on digit 0, both polarities
      for (int unsigned v = 0; v < 16; v++) begin
         logic [3:0] nv;
         nv = 4'(v);
         load_inputs({12'h000, nv}, {3'b000, nv[0]}, 4'hF, nv[1]);
         t = slot_after(n, 0);
         push($sformatf("nib%0h", v), t, ~dec_tab[v], ~nv[0], 4'hE);
         wait_until(t);
      end
      @(negedge clk);

      // Asynchronous reset in the middle of a slot
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      e = '{cyc: 0, name: "rst_mid", seg: 7'h7F, dp: 1'b1, an: 4'hF, fd: 1'b0};
      compare(e);
      @(negedge clk);
      release_seq();

      @(negedge clk);
      @(negedge clk);
      total++;
      if (sb_q.size() != 0) begin
         bad++;
         $display("FAIL sb_drain: got %0d pending, want 0", sb_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/sseg_scan_driver.md
Name: sseg_scan_driver

Overview:
Time-multiplexed driver for an N-digit common-anode seven-segment display. It latches a packed hex value, scans one digit per refresh slot, and decodes each nibble to segments. It adds leading-zero blanking, per-digit enables, decimal points and a frame-done strobe. It sits between the datapath (counters, ALU results) and the board display pins.

Parameters:
NUM_DIGITS, 4, number of digits scanned (1..8)
REFRESH_DIV, 100000, clock cycles each digit stays lit (>=2)
SEG_ACTIVE_LOW, 1, 1: seg/dp driven low-true; 0: high-true
AN_ACTIVE_LOW, 1, 1: anode selects low-true; 0: high-true

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
value  in  4*NUM_DIGITS  packed hex digits; nibble 0 (LSBs) is the rightmost digit
dp_in  in  NUM_DIGITS  decimal point request per digit
digit_en  in  NUM_DIGITS  per-digit enable; 0 blanks that digit
lz_blank  in  1  1: suppress leading zeros
load  in  1  capture value/dp_in/digit_en/lz_blank into shadow registers
seg  out  7  segments {g,f,e,d,c,b,a}
dp  out  1  decimal point
an  out  NUM_DIGITS  one-hot anode select
frame_done  out  1  one-cycle pulse when digit index wraps to 0

Behaviour:
- Clock: single clock domain clk. Reset: asynchronous, active-low on rst_n. All state is flopped. All outputs are registered.
- Reset values: refresh counter 0, digit index 0, shadow registers 0, frame_done 0. seg, dp and an are all inactive (seg=7'b1111111, dp=1, an all 1 with default polarities).
- Shadow: on a cycle with load=1, all four inputs are captured at the clock edge. Scanning uses shadow contents only, so unloaded input changes never appear on the display.
- Refresh counter counts 0..REFRESH_DIV-1, then wraps to 0.
  - When the counter reaches REFRESH_DIV-1, the digit index increments on the same edge the counter wraps.
  - From index NUM_DIGITS-1, the index wraps to 0 and frame_done=1 for exactly that one cycle.
- Output register: every cycle, seg/dp/an are computed from the current index and shadow. New content therefore appears one cycle after an index change or a load.
- Decode table (active-high pattern gfedcba, inverted when SEG_ACTIVE_LOW=1):
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111
  - 8=1111111, 9=1101111, A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001
- Leading-zero rule:
  - With lz_blank=1, digit k is blanked if nibbles NUM_DIGITS-1..k are all zero and k>0.
  - Digit 0 is never LZ-blanked, so value 0 shows "0".
- Blanked digit: seg inactive and dp inactive. The digit can be blanked by digit_en=0 or by LZ.
  - An LZ-blanked digit keeps its anode asserted.
  - A digit_en=0 digit has its anode deasserted.
- Otherwise dp = dp_in[index] (polarity per SEG_ACTIVE_LOW). an asserts only bit [index].
- Simultaneous load and index advance: the output register uses the new index and the new shadow on the following edge. There is no mixed-state cycle.
- Reset mid-frame: immediate return to the reset values. After release, scanning restarts at digit 0 with a full REFRESH_DIV slot.
- NUM_DIGITS=1: index stays 0, and frame_done pulses every REFRESH_DIV cycles.

Test Plan:
- Reset with rst_n low mid-slot -> seg=7'h7F, an=4'hF, dp=1 immediately (asynchronous). After release, digit 0 is selected and holds for REFRESH_DIV cycles.
- REFRESH_DIV=4, load value=16'h12AF, all digit_en=1 -> in turn:
  - an=1110 with seg=0001110 (F)
  - an=1101 with seg=0001000 (A)
  - an=1011 with seg=0100100 (2)
  - an=0111 with seg=1111001 (1)
  - each held 4 cycles; frame_done pulses once per 16 cycles.
- lz_blank=1, value=16'h0005 -> digits 3..1 show seg=7'h7F with anodes cycling; digit 0 shows seg=0010010. value=16'h0000 -> digit 0 shows seg=1000000.
- digit_en=4'b1010, dp_in=4'b0010, value=16'h8888 -> digits 0 and 2 have no anode asserted. Digit 1 shows seg=0000000 with dp=0; digit 3 shows seg=0000000 with dp=1.
- Change value with load=0 -> display unchanged. Pulse load on the same cycle as a digit advance -> the next output cycle shows the new nibble for the new index.
- Sweep all 16 nibbles on digit 0 -> seg matches the decode table, inverted per SEG_ACTIVE_LOW. Repeat with SEG_ACTIVE_LOW=0 and AN_ACTIVE_LOW=0.
